icache_refill_arbiter: RTL and testbench
========================================

Name: icache_refill_arbiter

Overview:
Shares one instruction-memory refill port between NumRequesters instruction caches, each with at most one outstanding line refill. Round-robin arbitration with grant lock until downstream handshake. Each request is tagged with the requester index; tagged responses, possibly out of order, are routed back. Sits between the per-compute-unit instruction caches and the shared instruction memory / L2 interface.

Parameters:
NumRequesters, 4, number of instruction caches sharing the port (>=1)
CacheAddrWidth, 30, cacheline address width (PC width minus cacheline index bits)
LineWidth, 32, refill data width in bits (instructions per line times encoded instruction width)
IdWidth, NumRequesters>1 ? $clog2(NumRequesters) : 1, derived; do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  NumRequesters  per-cache refill request (cache mem_req)
req_ready_o  out  NumRequesters  per-cache request accepted (cache mem_ready)
req_addr_i  in  NumRequesters x CacheAddrWidth  per-cache cacheline address
rsp_valid_o  out  NumRequesters  per-cache one-hot response strobe (cache mem_valid)
rsp_data_o  out  LineWidth  refill data, broadcast to all caches
mem_req_o  out  1  downstream request valid
mem_ready_i  in  1  downstream request ready
mem_addr_o  out  CacheAddrWidth  downstream cacheline address
mem_id_o  out  IdWidth  requester tag
mem_valid_i  in  1  downstream response valid (no backpressure)
mem_id_i  in  IdWidth  response tag
mem_data_i  in  LineWidth  response data
err_o  out  1  sticky protocol error

Behaviour:
- One clock; reset synchronous, active-low. All state reset on clk_i edge while rst_ni=0.
- State: rr_ptr_q (IdWidth, reset 0), pending_q (NumRequesters, reset 0), lock_q (reset 0), lock_idx_q (reset 0), err_q (reset 0).
- Eligible[i] = req_valid_i[i] & ~pending_q[i].
- FSM ARB (lock_q=0): winner = first eligible index at or after rr_ptr_q, wrapping modulo NumRequesters. mem_req_o=1 if any eligible; mem_addr_o/mem_id_o from winner. If mem_ready_i: req_ready_o[winner]=1, pending[winner] set, rr_ptr <- winner+1 (wraps at NumRequesters-1 -> 0), stay ARB. Else -> LOCKED with lock_idx=winner.
- LOCKED (lock_q=1): present lock_idx_q only, ignoring others; addr taken live from req_addr_i[lock_idx]. On mem_ready_i: handshake as above, -> ARB. Requesters must hold valid/addr until ready; a dropped req_valid in LOCKED sets err, -> ARB without handshake.
- Request path combinational, zero latency; mem_req_o never depends on mem_ready_i.
- Response: mem_valid_i -> rsp_valid_o = onehot(mem_id_i) same cycle, rsp_data_o = mem_data_i; pending[mem_id_i] cleared next edge. rsp_data_o = 0 when mem_valid_i=0.
- Response for non-pending id or id >= NumRequesters: rsp_valid_o all 0, err set.
- Same cycle response to i and request from i: i not eligible (pending_q), re-eligible next cycle (1-cycle minimum gap).
- Same cycle response to i and grant to j≠i: both proceed.
- All requesters pending: mem_req_o=0.
- Reset outputs: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, mem_req_o=0, mem_addr_o=0, mem_id_o=0, err_o=0. Reset mid-transaction drops lock and pending; responses to pre-reset requests after reset set err. Downstream drain before reset is the system's responsibility.
- NumRequesters=1: mem_id_o=0; arbitration degenerates to pass-through plus pending tracking.

Optional Feature:
ICACHE_REFILL_ARB_PERF_EN: adds perf_grant_cnt_o (NumRequesters x 32, per-requester handshake count) and perf_stall_cnt_o (32, cycles with mem_req_o=1 & mem_ready_i=0). Counters wrap at 2^32, sync reset to 0. Without the macro these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package icache_refill_pkg: arb_state_e (ARB, LOCKED), requester id type, and response-routing onehot helper function.
- Sub-module rr_pick: combinational round-robin picker (eligible vector + pointer -> winner index, any_valid). Reused by the arbiter; no state inside.

Test Plan:
- Single requester 2, addr 0x100, mem_ready_i=1: same-cycle mem_req_o=1, mem_id_o=2, req_ready_o=4'b0100. Response id 2 -> rsp_valid_o=4'b0100 with data.
- All four requesting, ready always 1: grants 0,1,2,3 in consecutive cycles; no further grants until responses arrive.
- Requester 1 granted, mem_ready_i low 3 cycles while requester 0 raises: mem_id_o stays 1 for 4 cycles; requester 0 granted the cycle after the handshake.
- Responses out of order (id 3 then id 0): each routed one-hot; both re-grantable next cycle. Response and new request for id 3 in the same cycle: grant delayed exactly one cycle.
- Response with id 1 while pending_q[1]=0: rsp_valid_o=0 and err_o=1 persisting until reset. Reset while locked: all outputs 0 next cycle.
- With ICACHE_REFILL_ARB_PERF_EN, 10 grants to requester 0 with 5 stall cycles: perf_grant_cnt_o[0]=10, perf_stall_cnt_o=5.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the instruction-cache refill arbiter.
// Tags are carried in a fixed-width id type; requester counts up to MaxRequesters are supported.
package icache_refill_pkg;

   localparam int unsigned MaxRequesters = 64;
   localparam int unsigned MaxIdWidth    = 6;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef logic [MaxIdWidth-1:0] req_id_t;

   function automatic logic [MaxRequesters-1:0] id_onehot(input req_id_t id);
      logic [MaxRequesters-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/icache_refill_arbiter_rr_pick.sv
// Stateless round-robin picker: lowest eligible index at or after the pointer,
// otherwise wraps to the lowest eligible index overall.
module rr_pick #(
   parameter int unsigned NumRequesters = 4,
   parameter int unsigned IdWidth       = 2
) (
   input  logic [NumRequesters-1:0] i_eligible,
   input  logic [IdWidth-1:0]       i_ptr,
   output logic [IdWidth-1:0]       o_winner,
   output logic                     o_any
);

   logic [IdWidth-1:0] w_hi;
   logic [IdWidth-1:0] w_lo;
   logic               w_hi_found;

   always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      // Descending scan so the last assignment is the lowest matching index.
      for (int i = NumRequesters - 1; i >= 0; i--) begin
         if (i_eligible[i]) begin
            w_lo = IdWidth'(i);
            if (IdWidth'(i) >= i_ptr) begin
               w_hi       = IdWidth'(i);
               w_hi_found = 1'b1;
            end
         end
      end
   end

   assign o_any    = |i_eligible;
   assign o_winner = w_hi_found ? w_hi : w_lo;

endmodule

// File: rtl/icache_refill_arbiter.sv
// Shares one refill port among NumRequesters instruction caches with tagged,
// out-of-order responses. Optional perf counters: ICACHE_REFILL_ARB_PERF_EN.
module icache_refill_arbiter
   import icache_refill_pkg::*;
#(
   parameter int unsigned NumRequesters  = 4,
   parameter int unsigned CacheAddrWidth = 30,
   parameter int unsigned LineWidth      = 32,
   parameter int unsigned IdWidth        = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic [NumRequesters-1:0]                     req_valid_i,
   output logic [NumRequesters-1:0]                     req_ready_o,
   input  logic [NumRequesters-1:0][CacheAddrWidth-1:0] req_addr_i,
   output logic [NumRequesters-1:0]                     rsp_valid_o,
   output logic [LineWidth-1:0]                         rsp_data_o,
   output logic                                         mem_req_o,
   input  logic                                         mem_ready_i,
   output logic [CacheAddrWidth-1:0]                    mem_addr_o,
   output logic [IdWidth-1:0]                           mem_id_o,
   input  logic                                         mem_valid_i,
   input  logic [IdWidth-1:0]                           mem_id_i,
   input  logic [LineWidth-1:0]                         mem_data_i,
`ifdef ICACHE_REFILL_ARB_PERF_EN
   output logic [NumRequesters-1:0][31:0]               perf_grant_cnt_o,
   output logic [31:0]                                  perf_stall_cnt_o,
`endif
   output logic                                         err_o
);

   arb_state_e                r_state, w_state_nxt;
   logic [IdWidth-1:0]        r_rr_ptr, r_lock_idx, w_lock_idx_nxt, w_pick, w_sel;
   logic [NumRequesters-1:0]  r_pending, w_eligible, w_set, w_clr;
   logic                      r_err, w_any, w_req, w_hs, w_id_ok, w_lock_vld, w_drop;
   logic [CacheAddrWidth-1:0] w_addr;

   assign w_eligible = req_valid_i & ~r_pending;

   rr_pick #(
      .NumRequesters(NumRequesters),
      .IdWidth      (IdWidth)
   ) u_rr_pick (
      .i_eligible(w_eligible),
      .i_ptr     (r_rr_ptr),
      .o_winner  (w_pick),
      .o_any     (w_any)
   );

   // Loop-based selects keep unused tag codes harmless when the count is not a power of two.
   always_comb begin
      w_lock_vld = 1'b0;
      w_addr     = '0;
      w_id_ok    = 1'b0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (r_lock_idx == IdWidth'(i)) w_lock_vld = req_valid_i[i];
         if (w_sel == IdWidth'(i))      w_addr     = req_addr_i[i];
         if (mem_id_i == IdWidth'(i))   w_id_ok    = r_pending[i];
      end
   end

   assign w_sel = (r_state == LOCKED) ? r_lock_idx : w_pick;
   assign w_req = rst_ni & ((r_state == LOCKED) ? w_lock_vld : w_any);
   assign w_hs  = w_req & mem_ready_i;
   assign w_set = w_hs ? NumRequesters'(id_onehot(req_id_t'(w_sel))) : '0;
   assign w_clr = (rst_ni && mem_valid_i && w_id_ok) ? NumRequesters'(id_onehot(req_id_t'(mem_id_i))) : '0;

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_idx_nxt = r_lock_idx;
      w_drop         = 1'b0;
      case (r_state)
         ARB: begin
            if (w_any && !mem_ready_i) begin
               w_state_nxt    = LOCKED;
               w_lock_idx_nxt = w_pick;
            end
         end
         LOCKED: begin
            if (!w_lock_vld) begin
               w_drop      = 1'b1;
               w_state_nxt = ARB;
            end else if (mem_ready_i) begin
               w_state_nxt = ARB;
            end
         end
         default: w_state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= ARB;
         r_lock_idx <= '0;
         r_rr_ptr   <= '0;
         r_pending  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_idx <= w_lock_idx_nxt;
         r_pending  <= (r_pending & ~w_clr) | w_set;
         if (w_hs)
            r_rr_ptr <= (w_sel == IdWidth'(NumRequesters - 1)) ? '0 : w_sel + IdWidth'(1);
         if (w_drop || (mem_valid_i && !w_id_ok))
            r_err <= 1'b1;
      end
   end

   assign mem_req_o   = w_req;
   assign mem_id_o    = w_req ? w_sel : '0;
   assign mem_addr_o  = w_req ? w_addr : '0;
   assign req_ready_o = w_set;
   assign rsp_valid_o = w_clr;
   assign rsp_data_o  = (rst_ni && mem_valid_i) ? mem_data_i : '0;
   assign err_o       = r_err;

`ifdef ICACHE_REFILL_ARB_PERF_EN
   logic [NumRequesters-1:0][31:0] r_grant_cnt;
   logic [31:0]                    r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NumRequesters; i++)
            if (w_set[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
         if (mem_req_o && !mem_ready_i)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign perf_grant_cnt_o = r_grant_cnt;
   assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed scenario tasks plus a randomized run against a queue-based reference model.
module tb_icache_refill_arbiter;

   localparam int N  = 4;
   localparam int AW = 30;
   localparam int LW = 32;
   localparam int IW = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [N-1:0]         req_valid, req_ready, rsp_valid;
   logic [N-1:0][AW-1:0] req_addr;
   logic [LW-1:0]        rsp_data, mem_data;
   logic                 mem_req, mem_ready, mem_valid, err;
   logic [AW-1:0]        mem_addr;
   logic [IW-1:0]        mem_id_o, mem_id;
`ifdef ICACHE_REFILL_ARB_PERF_EN
   logic [N-1:0][31:0]   perf_grant;
   logic [31:0]          perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_refill_arbiter #(
      .NumRequesters (N),
      .CacheAddrWidth(AW),
      .LineWidth     (LW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_addr_i (req_addr),
      .rsp_valid_o(rsp_valid),
      .rsp_data_o (rsp_data),
      .mem_req_o  (mem_req),
      .mem_ready_i(mem_ready),
      .mem_addr_o (mem_addr),
      .mem_id_o   (mem_id_o),
      .mem_valid_i(mem_valid),
      .mem_id_i   (mem_id),
      .mem_data_i (mem_data),
`ifdef ICACHE_REFILL_ARB_PERF_EN
      .perf_grant_cnt_o(perf_grant),
      .perf_stall_cnt_o(perf_stall),
`endif
      .err_o      (err)
   );

   task automatic idle();
      req_valid = '0; mem_ready = 1'b0; mem_valid = 1'b0; mem_id = '0; mem_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      for (int i = 0; i < N; i++) req_addr[i] = AW'(32'h40 + i);
      rst_n = 1'b0;
      tick();
      #1;
      checks++; if ({req_ready, rsp_valid, mem_req, err} !== '0) begin errors++;
         $display("FAIL reset_ctl got %b exp 0", {req_ready, rsp_valid, mem_req, err}); end
      checks++; if ({rsp_data, mem_addr, mem_id_o} !== '0) begin errors++;
         $display("FAIL reset_data got %h exp 0", {rsp_data, mem_addr, mem_id_o}); end
      rst_n = 1'b1;
      tick();
      #1;
      checks++; if ({mem_req, err} !== 2'b00) begin errors++;
         $display("FAIL reset_release got %b exp 00", {mem_req, err}); end
   endtask

   task automatic test_single();
      logic [LW-1:0] d;
      do_reset();
      req_valid = 4'b0100; req_addr[2] = 30'h100; mem_ready = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_req got %b exp 1", mem_req); end
      checks++; if (mem_id_o !== 2'd2) begin errors++; $display("FAIL single_id got %0d exp 2", mem_id_o); end
      checks++; if (mem_addr !== 30'h100) begin errors++; $display("FAIL single_addr got %h exp 100", mem_addr); end
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
      tick();
      d = $urandom;
      req_valid = '0; mem_ready = 1'b0; mem_valid = 1'b1; mem_id = 2'd2; mem_data = d;
      #1;
      checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp got %b exp 0100", rsp_valid); end
      checks++; if (rsp_data !== d) begin errors++; $display("FAIL single_data got %h exp %h", rsp_data, d); end
      tick();
      idle();
      #1;
      checks++; if ({rsp_valid, rsp_data, err} !== '0) begin errors++;
         $display("FAIL single_quiet got %h exp 0", {rsp_valid, rsp_data, err}); end
   endtask

   task automatic test_all_four();
      do_reset();
      for (int i = 0; i < N; i++) req_addr[i] = AW'(32'h10 * i + 1);
      req_valid = 4'b1111; mem_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         #1;
         checks++; if ({mem_req, mem_id_o, req_ready, mem_addr} !== {1'b1, IW'(k), N'(1) << k, AW'(32'h10 * k + 1)}) begin
            errors++; $display("FAIL all4_grant%0d got id %0d ready %b exp id %0d", k, mem_id_o, req_ready, k); end
         tick();
      end
      #1;
      checks++; if ({mem_req, req_ready} !== 5'b0) begin errors++;
         $display("FAIL all4_full got %b exp 0", {mem_req, req_ready}); end
      tick();
      mem_valid = 1'b1; mem_id = 2'd1; mem_data = 32'hCAFE0001;
      #1;
      checks++; if ({mem_req, rsp_valid} !== 5'b00010) begin errors++;
         $display("FAIL all4_rsp got %b exp 00010", {mem_req, rsp_valid}); end
      tick();
      mem_valid = 1'b0;
      #1;
      checks++; if ({mem_req, mem_id_o, req_ready} !== {1'b1, 2'd1, 4'b0010}) begin errors++;
         $display("FAIL all4_regrant got id %0d ready %b exp id 1 ready 0010", mem_id_o, req_ready); end
      tick();
      idle();
   endtask

   task automatic test_lock();
      do_reset();
      req_addr[0] = 30'hA0; req_addr[1] = 30'hB1;
      req_valid = 4'b0010; mem_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) req_valid[0] = 1'b1;
         mem_ready = (c == 3);
         #1;
         checks++; if ({mem_req, mem_id_o, mem_addr} !== {1'b1, 2'd1, 30'hB1}) begin errors++;
            $display("FAIL lock_hold%0d got id %0d addr %h exp id 1 addr b1", c, mem_id_o, mem_addr); end
         checks++; if (req_ready !== ((c == 3) ? 4'b0010 : 4'b0000)) begin errors++;
            $display("FAIL lock_ready%0d got %b", c, req_ready); end
         tick();
      end
      #1;
      checks++; if ({mem_id_o, req_ready} !== {2'd0, 4'b0001}) begin errors++;
         $display("FAIL lock_next got id %0d ready %b exp id 0 ready 0001", mem_id_o, req_ready); end
      tick();
      idle();
   endtask

   task automatic test_out_of_order();
      do_reset();
      req_valid = 4'b1001; mem_ready = 1'b1;
      #1;
      checks++; if (mem_id_o !== 2'd0) begin errors++; $display("FAIL ooo_g0 got %0d exp 0", mem_id_o); end
      tick();
      #1;
      checks++; if (mem_id_o !== 2'd3) begin errors++; $display("FAIL ooo_g3 got %0d exp 3", mem_id_o); end
      tick();
      req_valid = '0; mem_valid = 1'b1; mem_id = 2'd3; mem_data = 32'h3333;
      #1;
      checks++; if ({mem_req, rsp_valid} !== 5'b01000) begin errors++;
         $display("FAIL ooo_rsp3 got %b exp 01000", {mem_req, rsp_valid}); end
      tick();
      mem_id = 2'd0; mem_data = 32'h0000_1111; req_valid = 4'b1000;
      #1;
      checks++; if ({rsp_valid, mem_req, mem_id_o, req_ready} !== {4'b0001, 1'b1, 2'd3, 4'b1000}) begin errors++;
         $display("FAIL ooo_rsp0 got rsp %b id %0d ready %b", rsp_valid, mem_id_o, req_ready); end
      tick();
      mem_valid = 1'b0; req_valid = 4'b0001;
      #1;
      checks++; if ({mem_id_o, req_ready} !== {2'd0, 4'b0001}) begin errors++;
         $display("FAIL ooo_regrant0 got id %0d ready %b", mem_id_o, req_ready); end
      tick();
      req_valid = 4'b1000; mem_valid = 1'b1; mem_id = 2'd3;
      #1;
      checks++; if ({mem_req, rsp_valid} !== 5'b01000) begin errors++;
         $display("FAIL gap_same got %b exp 01000", {mem_req, rsp_valid}); end
      tick();
      mem_valid = 1'b0;
      #1;
      checks++; if ({mem_req, mem_id_o, req_ready} !== {1'b1, 2'd3, 4'b1000}) begin errors++;
         $display("FAIL gap_next got id %0d ready %b exp id 3 ready 1000", mem_id_o, req_ready); end
      tick();
      idle();
   endtask

   task automatic test_errors();
      do_reset();
      mem_valid = 1'b1; mem_id = 2'd1; mem_data = 32'hDEAD;
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bad_rsp got %b exp 0000", rsp_valid); end
      tick();
      idle();
      tick(); tick(); tick();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b exp 1", err); end
      do_reset();
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      #1;
      checks++; if ({mem_req, req_ready} !== 5'b0) begin errors++;
         $display("FAIL drop_req got %b exp 0", {mem_req, req_ready}); end
      tick();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", err); end
   endtask

   task automatic test_reset_locked();
      do_reset();
      req_valid = 4'b0001; mem_ready = 1'b1;
      tick();
      req_valid = 4'b0010; mem_ready = 1'b0;
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      #1;
      checks++; if ({req_ready, rsp_valid, mem_req, err, rsp_data, mem_addr, mem_id_o} !== '0) begin errors++;
         $display("FAIL rstlock_out got req %b id %0d", mem_req, mem_id_o); end
      rst_n = 1'b1;
      req_valid = 4'b0100; mem_ready = 1'b1;
      #1;
      checks++; if ({mem_id_o, req_ready} !== {2'd2, 4'b0100}) begin errors++;
         $display("FAIL rstlock_unlock got id %0d ready %b exp 2 0100", mem_id_o, req_ready); end
      tick();
      idle();
      mem_valid = 1'b1; mem_id = 2'd0;
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL stale_rsp got %b exp 0000", rsp_valid); end
      tick();
      idle();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err got %b exp 1", err); end
   endtask

   task automatic test_random();
      int q[$];
      int m_ptr, m_lock, rsp_sel, exp_id;
      logic exp_req;
      logic [N-1:0] pend, exp_ready, exp_rsp;
      do_reset();
      m_ptr = 0; m_lock = -1;
      for (int c = 0; c < 400; c++) begin
         pend = '0;
         foreach (q[j]) pend[q[j]] = 1'b1;
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && !pend[i] && $urandom_range(2) == 0) begin
               req_valid[i] = 1'b1; req_addr[i] = AW'($urandom);
            end
         mem_ready = 1'($urandom_range(1));
         rsp_sel = -1; mem_valid = 1'b0; mem_id = '0; mem_data = '0;
         if (q.size() > 0 && $urandom_range(2) == 0) begin
            rsp_sel = $urandom_range(q.size() - 1);
            mem_valid = 1'b1; mem_id = IW'(q[rsp_sel]); mem_data = $urandom;
         end
         exp_req = 1'b0; exp_id = 0;
         if (m_lock >= 0) begin
            exp_id = m_lock; exp_req = req_valid[m_lock];
         end else begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (!exp_req && req_valid[j] && !pend[j]) begin exp_req = 1'b1; exp_id = j; end
            end
         end
         exp_ready = (exp_req && mem_ready) ? (N'(1) << exp_id) : '0;
         exp_rsp   = (rsp_sel >= 0) ? (N'(1) << q[rsp_sel]) : '0;
         #1;
         checks++; if (mem_req !== exp_req || req_ready !== exp_ready ||
                       (exp_req && {mem_id_o, mem_addr} !== {IW'(exp_id), req_addr[exp_id]})) begin errors++;
            $display("FAIL rnd_req c%0d got req %b id %0d ready %b exp req %b id %0d ready %b",
                     c, mem_req, mem_id_o, req_ready, exp_req, exp_id, exp_ready); end
         checks++; if (rsp_valid !== exp_rsp || rsp_data !== mem_data) begin errors++;
            $display("FAIL rnd_rsp c%0d got %b %h exp %b %h", c, rsp_valid, rsp_data, exp_rsp, mem_data); end
         @(posedge clk);
         #1;
         if (rsp_sel >= 0) q.delete(rsp_sel);
         if (exp_req && mem_ready) begin
            q.push_back(exp_id);
            req_valid[exp_id] = 1'b0;
            m_ptr = (exp_id + 1) % N;
            m_lock = -1;
         end else if (exp_req) begin
            m_lock = exp_id;
         end
         @(negedge clk);
      end
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err got %b exp 0", err); end
      idle();
   endtask

`ifdef ICACHE_REFILL_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      req_addr[0] = 30'h77;
      for (int g = 0; g < 10; g++) begin
         req_valid = 4'b0001; mem_ready = (g >= 5);
         tick();
         if (g < 5) begin mem_ready = 1'b1; tick(); end
         req_valid = '0; mem_ready = 1'b0; mem_valid = 1'b1; mem_id = 2'd0;
         tick();
         mem_valid = 1'b0;
      end
      #1;
      checks++; if (perf_grant[0] !== 32'd10) begin errors++; $display("FAIL perf_grant got %0d exp 10", perf_grant[0]); end
      checks++; if (perf_grant[1] !== 32'd0) begin errors++; $display("FAIL perf_grant1 got %0d exp 0", perf_grant[1]); end
      checks++; if (perf_stall !== 32'd5) begin errors++; $display("FAIL perf_stall got %0d exp 5", perf_stall); end
   endtask
`endif

   initial begin
      req_addr = '0;
      idle();
      test_reset();
      test_single();
      test_all_four();
      test_lock();
      test_out_of_order();
      test_errors();
      test_reset_locked();
      test_random();
`ifdef ICACHE_REFILL_ARB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
